// File: rtl/nbits_cla_adder.sv
// Two-level carry-lookahead adder: {cout,s} = a + b + cin over N bits, GROUP-bit lookahead groups.
// Optional output register is enabled by defining NBITS_CLA_ADDER_REG_OUT_EN (default: combinational).
module nbits_cla_adder #(
  parameter int N     = 4,
  parameter int GROUP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int NG = (N + GROUP - 1) / GROUP;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic [N-1:0] grp_g;
  logic [N-1:0] grp_p;
  logic [NG:0]  grp_c;
  logic [N-1:0] s_comb;
  logic         cout_comb;

  // Flat sum-of-products carry out of position `top`:
  //   c0 & p[0..top]  |  OR over k<=top of ( gv[k] & p[k+1..top] )
  // Each product term is formed independently, so no term waits on another carry.
  function automatic logic la_carry(
    input logic [N-1:0] gv,
    input logic [N-1:0] pv,
    input logic         c0,
    input int           top
  );
    logic acc;
    logic term;
    acc = c0;
    for (int m = 0; m < N; m++)
      if (m <= top) acc = acc & pv[m];
    for (int k = 0; k < N; k++) begin
      if (k <= top) begin
        term = gv[k];
        for (int m = 0; m < N; m++)
          if ((m > k) && (m <= top)) term = term & pv[m];
        acc = acc | term;
      end
    end
    return acc;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  // First lookahead level: carries inside each group, plus the group (G,P) pair.
  // The last group narrows to N mod GROUP bits when N is not a multiple of GROUP.
  for (genvar gi = 0; gi < NG; gi++) begin : grp
    localparam int LO = gi * GROUP;
    localparam int W  = ((N - LO) < GROUP) ? (N - LO) : GROUP;

    logic [N-1:0] gv;
    logic [N-1:0] pv;

    always_comb begin
      gv        = '0;
      pv        = '0;
      gv[W-1:0] = g[LO +: W];
      pv[W-1:0] = p[LO +: W];
    end

    assign grp_g[gi] = la_carry(gv, pv, 1'b0, W - 1);
    assign grp_p[gi] = &pv[W-1:0];
    assign c[LO]     = grp_c[gi];

    for (genvar j = 1; j < W; j++) begin : inner
      assign c[LO + j] = la_carry(gv, pv, grp_c[gi], j - 1);
    end
  end

  for (genvar gi = NG; gi < N; gi++) begin : grp_pad
    assign grp_g[gi] = 1'b0;
    assign grp_p[gi] = 1'b0;
  end

  // Second lookahead level: every group carry-in comes straight from cin and (G,P).
  assign grp_c[0] = cin;
  for (genvar k = 0; k < NG; k++) begin : top_la
    assign grp_c[k + 1] = la_carry(grp_g, grp_p, cin, k);
  end

  assign c[N]      = grp_c[NG];
  assign s_comb    = p ^ c[N-1:0];
  assign cout_comb = c[N];

`ifdef NBITS_CLA_ADDER_REG_OUT_EN
  // Output register stage: one-cycle latency, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= s_comb;
      cout <= cout_comb;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign s              = s_comb;
  assign cout           = cout_comb;
`endif

endmodule

// File: tb/tb_nbits_cla_adder.sv
// Scoreboard bench for nbits_cla_adder: three instances (N=4/G=4, N=4/G=2, N=6/G=4) share cin.
// Works with or without NBITS_CLA_ADDER_REG_OUT_EN; latency and reset expectations follow the macro.
module tb_nbits_cla_adder;

`ifdef NBITS_CLA_ADDER_REG_OUT_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a4 = 4'd3;
  logic [3:0] b4 = 4'd5;
  logic [5:0] a6 = 6'd3;
  logic [5:0] b6 = 6'd5;
  logic       cin = 1'b0;
  logic [3:0] s_a;
  logic [3:0] s_b;
  logic [5:0] s_c;
  logic       cout_a;
  logic       cout_b;
  logic       cout_c;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] e4;
    logic [6:0] e6;
    string      tag;
  } exp_t;

  exp_t sb[$];

  nbits_cla_adder #(.N(4), .GROUP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .s(s_a), .cout(cout_a)
  );

  nbits_cla_adder #(.N(4), .GROUP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin), .s(s_b), .cout(cout_b)
  );

  nbits_cla_adder #(.N(6), .GROUP(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .a(a6), .b(b6), .cin(cin), .s(s_c), .cout(cout_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] e4, input logic [6:0] e6);
    check({tag, "_n4g4"}, {27'd0, cout_a, s_a}, {27'd0, e4});
    check({tag, "_n4g2"}, {27'd0, cout_b, s_b}, {27'd0, e4});
    check({tag, "_n6g4"}, {25'd0, cout_c, s_c}, {25'd0, e6});
  endtask

  // Drive one vector after the falling edge, record its reference sum, then
  // compare once the DUT has had its latency (a rising edge when registered).
  task automatic apply(input string tag, input logic [3:0] x, input logic [3:0] y,
                       input logic [5:0] x6, input logic [5:0] y6, input logic ci);
    exp_t e;
    @(negedge clk);
    a4  = x;
    b4  = y;
    a6  = x6;
    b6  = y6;
    cin = ci;
    e.e4  = 5'(x) + 5'(y) + 5'(ci);
    e.e6  = 7'(x6) + 7'(y6) + 7'(ci);
    e.tag = tag;
    sb.push_back(e);
    if (REG) @(posedge clk);
    #1;
    e = sb.pop_front();
    check_all(e.tag, e.e4, e.e6);
  endtask

  initial begin
    #1;
    // Reset state: registered outputs cleared, combinational outputs follow inputs.
    if (REG) check_all("reset", 5'd0, 7'd0);
    else     check_all("reset", 5'd8, 7'd8);
    @(negedge clk);
    rst_n = 1'b1;

    apply("a3_b5",        4'd3,  4'd5,  6'd3,  6'd5,  1'b0);
    apply("all_ones_cin", 4'd15, 4'd15, 6'd63, 6'd63, 1'b1);
    apply("all_zero",     4'd0,  4'd0,  6'd0,  6'd0,  1'b0);
    apply("a9_b7_chain",  4'd9,  4'd7,  6'd63, 6'd1,  1'b0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      apply("exhaustive", v[3:0], v[7:4], 6'($urandom), 6'($urandom), v[8]);
    end

    for (int i = 0; i < 1000; i++)
      apply("random", 4'($urandom), 4'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));

    // Mid-stream reset: an in-flight vector is dropped and never shows up later.
    @(negedge clk);
    a4  = 4'd12;
    b4  = 4'd7;
    a6  = 6'd40;
    b6  = 6'd30;
    cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    if (REG) check_all("rst_async", 5'd0, 7'd0);
    else     check_all("rst_async", 5'd20, 7'd71);
    @(posedge clk);
    #1;
    if (REG) check_all("rst_hold", 5'd0, 7'd0);
    else     check_all("rst_hold", 5'd20, 7'd71);
    @(negedge clk);
    rst_n = 1'b1;
    apply("after_rst", 4'd6, 4'd5, 6'd33, 6'd31, 1'b0);
    apply("after_rst2", 4'd15, 4'd1, 6'd63, 6'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nbits_cla_adder.md
NBITS_CLA_ADDER -- requirements
Module: nbits_cla_adder

Interface
REQ-001 Parameter: N, default 4, operand width in bits (N >= 1).
REQ-002 Parameter: GROUP, default 4, carry-lookahead group width in bits (1 <= GROUP <= N).
REQ-003 Port: clk  input  1  single system clock, rising-edge active.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: a  input  N  addend A, unsigned.
REQ-006 Port: b  input  N  addend B, unsigned.
REQ-007 Port: cin  input  1  carry-in.
REQ-008 Port: s  output  N  sum bits.
REQ-009 Port: cout  output  1  carry-out of the MSB.
REQ-010 Port order SHALL be clk, rst_n, a, b, cin, s, cout.
REQ-011 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-012 {cout,s} SHALL equal a + b + cin as an exact (N+1)-bit unsigned sum for all input combinations.
REQ-013 Per-bit generate g[i] = a[i]&b[i] and propagate p[i] = a[i]^b[i] SHALL be formed.
REQ-014 Carries inside each GROUP-bit group SHALL be computed by lookahead equations from g, p and the group carry-in, not by rippling.
REQ-015 Each group SHALL produce group generate G and group propagate P.
REQ-016 Group carries SHALL be derived by a second lookahead level over (G,P) from cin.
REQ-017 s[i] SHALL equal p[i] ^ c[i], with c[0] = cin; cout SHALL equal c[N].
REQ-018 When N is not a multiple of GROUP, the last group SHALL be a partial group of N mod GROUP bits with identical semantics.
REQ-019 Wrap-around: a = b = all-ones with cin = 1 SHALL give s = all-ones and cout = 1; all-zero inputs with cin = 0 SHALL give s = 0 and cout = 0.
REQ-020 The block SHALL contain no state other than the optional output register (REQ-024).

Reset
REQ-021 With the output register compiled in, rst_n = 0 SHALL asynchronously force s = 0 and cout = 0, independent of clk.
REQ-022 After rst_n deasserts, the first rising clk edge SHALL capture the current sum.
REQ-023 Asserting reset mid-operation SHALL discard the in-flight result; no stale value SHALL appear after release.

Configuration
REQ-024 Macro NBITS_CLA_ADDER_REG_OUT_EN SHALL control the output register.
REQ-025 Macro defined: s and cout SHALL be registered on rising clk, with 1-cycle latency from a/b/cin to outputs; a new result SHALL appear every cycle.
REQ-026 Macro undefined: s and cout SHALL be purely combinational, with zero latency; clk and rst_n SHALL remain as ports but be unused.

Verification
REQ-027 a=3, b=5, cin=0 -> {cout,s} = 8 (s=8, cout=0).
REQ-028 a=15, b=15, cin=1 -> s=15, cout=1; a=0, b=0, cin=0 -> s=0, cout=0.
REQ-029 a=9, b=7, cin=0 -> s=0, cout=1, exercising the full lookahead carry chain through all groups.
REQ-030 Randomised regression (N=4, at least 1000 vectors) -> {cout,s} == a+b+cin for every vector; exhaustive 512-case sweep passes.
REQ-031 With REG_OUT_EN defined, drive rst_n=0 mid-stream -> s=0 and cout=0 immediately; after release, the result appears one edge after the inputs are applied.
REQ-032 N=6, GROUP=4 (partial group), a=63, b=1, cin=0 -> s=0, cout=1.
